// File: rtl/reaction_round_ctrl.sv
// Round sequencer for the button-reaction minigame: picks a one-hot target from a
// free-running LFSR, runs a shrinking per-round window and tracks score/lives/rounds.
module reaction_round_ctrl #(
    parameter int unsigned  ROUND_TICKS    = 50000000,
    parameter int unsigned  DEC_TICKS      = 5000000,
    parameter int unsigned  MIN_TICKS      = 10000000,
    parameter int unsigned  MAX_ROUNDS     = 10,
    parameter int unsigned  LIVES          = 3,
    parameter int unsigned  FEEDBACK_TICKS = 25000000,
    parameter logic [15:0]  SEED           = 16'hACE1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] buttons,
    output logic [3:0] target,
    output logic       target_valid,
    output logic       hit_pulse,
    output logic       miss_pulse,
    output logic [7:0] score,
    output logic [3:0] lives,
    output logic [7:0] round_num,
    output logic       game_over,
    output logic       win,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IDLE         = 3'd0,
        S_ARM          = 3'd1,
        S_WAIT_RELEASE = 3'd2,
        S_PLAY         = 3'd3,
        S_HIT          = 3'd4,
        S_MISS         = 3'd5,
        S_DONE         = 3'd6
    } state_t;

    localparam logic [31:0] ROUND_W    = 32'(ROUND_TICKS);
    localparam logic [31:0] DEC_W      = 32'(DEC_TICKS);
    localparam logic [31:0] MIN_W      = 32'(MIN_TICKS);
    localparam logic [31:0] FB_W       = 32'(FEEDBACK_TICKS);
    localparam logic [7:0]  MAX_ROUNDS_W = 8'(MAX_ROUNDS);
    localparam logic [3:0]  LIVES_W    = 4'(LIVES);
    localparam logic [15:0] LFSR_MASK  = 16'hB400;

    state_t      state_q, state_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [3:0]  buttons_q, buttons_d;
    logic [1:0]  tgt_idx_q, tgt_idx_d;
    logic [31:0] timer_q, timer_d;
    logic [31:0] window_q, window_d;
    logic [31:0] fb_q, fb_d;
    logic [7:0]  score_q, score_d;
    logic [3:0]  lives_q, lives_d;
    logic [7:0]  round_q, round_d;
    logic        win_q, win_d;
    logic        hit_pulse_q, hit_pulse_d;
    logic        miss_pulse_q, miss_pulse_d;

    logic        press_evt;
    logic [1:0]  pick_idx;
    logic [3:0]  cur_target;
    logic [31:0] window_sub;
    logic [31:0] window_next;
    logic        do_next;

    always_comb begin
        lfsr_d      = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_MASK) : (lfsr_q >> 1);
        buttons_d   = buttons;
        press_evt   = |(buttons & ~buttons_q);
        cur_target  = 4'b0001 << tgt_idx_q;
        // Never repeat the previous target: bump the raw pick by one.
        pick_idx    = lfsr_q[1:0];
        if (pick_idx == tgt_idx_q) begin
            pick_idx = pick_idx + 2'd1;
        end
        window_sub  = (window_q > DEC_W) ? (window_q - DEC_W) : 32'd0;
        window_next = (window_sub > MIN_W) ? window_sub : MIN_W;
    end

    always_comb begin
        state_d      = state_q;
        tgt_idx_d    = tgt_idx_q;
        timer_d      = timer_q;
        window_d     = window_q;
        fb_d         = fb_q;
        score_d      = score_q;
        lives_d      = lives_q;
        round_d      = round_q;
        win_d        = win_q;
        hit_pulse_d  = 1'b0;
        miss_pulse_d = 1'b0;
        do_next      = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d  = S_ARM;
                    score_d  = 8'd0;
                    lives_d  = LIVES_W;
                    round_d  = 8'd1;
                    window_d = ROUND_W;
                    win_d    = 1'b0;
                end
            end
            S_ARM: begin
                tgt_idx_d = pick_idx;
                timer_d   = window_q;
                state_d   = S_WAIT_RELEASE;
            end
            S_WAIT_RELEASE: begin
                if (buttons == 4'd0) begin
                    state_d = S_PLAY;
                end
            end
            S_PLAY: begin
                if (press_evt && (buttons == cur_target)) begin
                    state_d     = S_HIT;
                    hit_pulse_d = 1'b1;
                    score_d     = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
                    fb_d        = FB_W;
                end else if (press_evt || (timer_q == 32'd1)) begin
                    state_d      = S_MISS;
                    miss_pulse_d = 1'b1;
                    lives_d      = lives_q - 4'd1;
                    fb_d         = FB_W;
                end else begin
                    timer_d = timer_q - 32'd1;
                end
            end
            S_HIT: begin
                if (fb_q == 32'd1) begin
                    do_next = 1'b1;
                end else begin
                    fb_d = fb_q - 32'd1;
                end
            end
            S_MISS: begin
                // Losing the last life ends the game even on the final round.
                if (fb_q == 32'd1) begin
                    if (lives_q == 4'd0) begin
                        state_d = S_DONE;
                        win_d   = 1'b0;
                    end else begin
                        do_next = 1'b1;
                    end
                end else begin
                    fb_d = fb_q - 32'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (do_next) begin
            if (round_q == MAX_ROUNDS_W) begin
                state_d = S_DONE;
                win_d   = 1'b1;
            end else begin
                round_d  = round_q + 8'd1;
                window_d = window_next;
                state_d  = S_ARM;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            lfsr_q       <= SEED;
            buttons_q    <= 4'd0;
            tgt_idx_q    <= 2'd0;
            timer_q      <= 32'd0;
            window_q     <= ROUND_W;
            fb_q         <= 32'd0;
            score_q      <= 8'd0;
            lives_q      <= LIVES_W;
            round_q      <= 8'd0;
            win_q        <= 1'b0;
            hit_pulse_q  <= 1'b0;
            miss_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            lfsr_q       <= lfsr_d;
            buttons_q    <= buttons_d;
            tgt_idx_q    <= tgt_idx_d;
            timer_q      <= timer_d;
            window_q     <= window_d;
            fb_q         <= fb_d;
            score_q      <= score_d;
            lives_q      <= lives_d;
            round_q      <= round_d;
            win_q        <= win_d;
            hit_pulse_q  <= hit_pulse_d;
            miss_pulse_q <= miss_pulse_d;
        end
    end

    // In ARM the freshly picked target is shown before it is registered.
    always_comb begin
        target = 4'd0;
        case (state_q)
            S_ARM:                  target = 4'b0001 << pick_idx;
            S_WAIT_RELEASE, S_PLAY: target = cur_target;
            default:                target = 4'd0;
        endcase
    end

    assign target_valid = (state_q == S_PLAY);
    assign hit_pulse    = hit_pulse_q;
    assign miss_pulse   = miss_pulse_q;
    assign score        = score_q;
    assign lives        = lives_q;
    assign round_num    = round_q;
    assign game_over    = (state_q == S_DONE);
    assign win          = win_q;
    assign state        = state_q;

endmodule
